fp_mul_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational FP multiplier.
- Adds generic exponent/mantissa widths, selectable round-to-nearest-even, zero/overflow/underflow handling with flags, and a sideband tag.
- Three register stages with valid/ready handshakes on both sides.
- Sits between the operand fetch logic and the accumulator in the tiny-nn datapath; absorbs downstream stalls without losing data.

---
 rtl/fp_mul_pipe.sv | 153 +++++++++++++++
 tb/tb_fp_mul_pipe.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control,
// optional round-to-nearest-even, overflow saturation and underflow flush.
module fp_mul_pipe #(
  parameter int ExpWidth     = 8,
  parameter int MantWidth    = 7,
  parameter int RoundNearest = 1,
  parameter int TagWidth     = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [ExpWidth+MantWidth:0]   op_a_i,
  input  logic [ExpWidth+MantWidth:0]   op_b_i,
  input  logic [TagWidth-1:0]           tag_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [ExpWidth+MantWidth:0]   result_o,
  output logic [TagWidth-1:0]           tag_o,
  output logic                          ovf_o,
  output logic                          unf_o
);

  localparam int W  = 1 + ExpWidth + MantWidth;
  localparam int XW = ExpWidth + 2;
  localparam int SW = MantWidth + 1;
  localparam int PW = 2 * SW;
  localparam logic signed [XW-1:0] BIAS  = XW'((2 ** (ExpWidth - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX  = XW'((2 ** ExpWidth) - 1);
  localparam logic signed [XW-1:0] EZERO = '0;

  // Returns {carry, mantissa}; pn is the normalised product without its hidden bit.
  function automatic logic [MantWidth:0] round_mant(input logic [PW-2:0] pn);
    logic [MantWidth-1:0] mant;
    logic guard, sticky, inc;
    mant   = pn[PW-2 -: MantWidth];
    guard  = pn[MantWidth];
    sticky = |pn[MantWidth-1:0];
    inc    = (RoundNearest != 0) && guard && (sticky || mant[0]);
    return {1'b0, mant} + {{MantWidth{1'b0}}, inc};
  endfunction

  // Returns {result, ovf, unf}; zero operands take priority over range checks.
  function automatic logic [W+1:0] sat_pack(input logic sgn, input logic zero,
                                            input logic signed [XW-1:0] e,
                                            input logic [MantWidth-1:0] mant);
    if (zero)            return {sgn, {(W-1){1'b0}}, 2'b00};
    else if (e <= EZERO) return {sgn, {(W-1){1'b0}}, 2'b01};
    else if (e >= EMAX)  return {sgn, {(W-1){1'b1}}, 2'b10};
    return {sgn, e[ExpWidth-1:0], mant, 2'b00};
  endfunction

  logic vld_p1_q, vld_p2_q, vld_p3_q;
  logic en_p1, en_p2, en_p3;

  assign en_p3      = !vld_p3_q || out_ready_i;
  assign en_p2      = !vld_p2_q || en_p3;
  assign en_p1      = !vld_p1_q || en_p2;
  assign in_ready_o = en_p1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      if (en_p1) vld_p1_q <= in_valid_i;
      if (en_p2) vld_p2_q <= vld_p1_q;
      if (en_p3) vld_p3_q <= vld_p2_q;
    end
  end

  // ---- Stage 1: sign, exponent sum, mantissa product, zero detect ----
  logic                 sgn_a, sgn_b;
  logic [ExpWidth-1:0]  exp_a, exp_b;
  logic [MantWidth-1:0] mant_a, mant_b;

  assign {sgn_a, exp_a, mant_a} = op_a_i;
  assign {sgn_b, exp_b, mant_b} = op_b_i;

  logic                 sgn_p1_q, zero_p1_q;
  logic signed [XW-1:0] esum_p1_q;
  logic [PW-1:0]        prod_p1_q;
  logic [TagWidth-1:0]  tag_p1_q;

  always_ff @(posedge clk_i) begin
    if (en_p1 && in_valid_i) begin
      sgn_p1_q  <= sgn_a ^ sgn_b;
      esum_p1_q <= $signed(XW'(exp_a) + XW'(exp_b));
      prod_p1_q <= PW'({1'b1, mant_a}) * PW'({1'b1, mant_b});
      zero_p1_q <= (exp_a == '0) || (exp_b == '0);
      tag_p1_q  <= tag_i;
    end
  end

  // ---- Stage 2: normalise and round ----
  logic                 norm_p1;
  logic [PW-1:0]        pn_p1;
  logic [MantWidth:0]   rnd_p1;
  logic signed [XW-1:0] eadj_p1;

  assign norm_p1 = prod_p1_q[PW-1];
  assign pn_p1   = norm_p1 ? prod_p1_q : (prod_p1_q << 1);
  assign rnd_p1  = round_mant(pn_p1[PW-2:0]);
  assign eadj_p1 = esum_p1_q + $signed({{(XW-1){1'b0}}, norm_p1})
                             + $signed({{(XW-1){1'b0}}, rnd_p1[MantWidth]});

  logic                 sgn_p2_q, zero_p2_q;
  logic signed [XW-1:0] exp_p2_q;
  logic [MantWidth-1:0] mant_p2_q;
  logic [TagWidth-1:0]  tag_p2_q;

  always_ff @(posedge clk_i) begin
    if (en_p2 && vld_p1_q) begin
      sgn_p2_q  <= sgn_p1_q;
      zero_p2_q <= zero_p1_q;
      exp_p2_q  <= eadj_p1;
      mant_p2_q <= rnd_p1[MantWidth-1:0];
      tag_p2_q  <= tag_p1_q;
    end
  end

  // ---- Stage 3: bias removal, special cases, pack ----
  logic signed [XW-1:0] ebias_p2;
  logic [W+1:0]         pack_d;
  logic [W-1:0]         result_q;
  logic [TagWidth-1:0]  tag_q;
  logic                 ovf_q, unf_q;

  assign ebias_p2 = exp_p2_q - BIAS;
  assign pack_d   = sat_pack(sgn_p2_q, zero_p2_q, ebias_p2, mant_p2_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_q <= '0;
      tag_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (en_p3 && vld_p2_q) begin
      result_q <= pack_d[W+1:2];
      tag_q    <= tag_p2_q;
      ovf_q    <= pack_d[1];
      unf_q    <= pack_d[0];
    end
  end

  assign out_valid_o = vld_p3_q;
  assign result_o    = result_q;
  assign tag_o       = tag_q;
  assign ovf_o       = ovf_q;
  assign unf_o       = unf_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed-vector bench for fp_mul_pipe (8-bit exponent, 7-bit mantissa), with
// a truncating instance alongside to cover the RoundNearest = 0 build.
module tb_fp_mul_pipe;
  localparam int EW = 8, MW = 7, TW = 4, W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, out_ready;
  logic [W-1:0]  op_a, op_b;
  logic [TW-1:0] tag;
  logic          in_ready, out_valid, ovf, unf;
  logic [W-1:0]  result;
  logic [TW-1:0] tag_out;
  logic          in_ready_t, out_valid_t, ovf_t, unf_t;
  logic [W-1:0]  result_t;
  logic [TW-1:0] tag_out_t;

  fp_mul_pipe #(.ExpWidth(EW), .MantWidth(MW), .RoundNearest(1), .TagWidth(TW)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_a_i(op_a), .op_b_i(op_b), .tag_i(tag), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .result_o(result), .tag_o(tag_out), .ovf_o(ovf), .unf_o(unf));

  fp_mul_pipe #(.ExpWidth(EW), .MantWidth(MW), .RoundNearest(0), .TagWidth(TW)) dut_trunc (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_t),
    .op_a_i(op_a), .op_b_i(op_b), .tag_i(tag), .out_valid_o(out_valid_t),
    .out_ready_i(out_ready), .result_o(result_t), .tag_o(tag_out_t), .ovf_o(ovf_t), .unf_o(unf_t));

  typedef struct {
    logic [W-1:0]  a, b;
    logic [TW-1:0] t;
    logic [W-1:0]  res, res_trunc;
    logic          ovf, unf;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input int i);
    int n;
    tick();
    op_a = vecs[i].a; op_b = vecs[i].b; tag = vecs[i].t;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk($sformatf("v%0d in_ready", i), {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk($sformatf("v%0d latency", i), n, 32'd3);
    chk($sformatf("v%0d result", i), {16'b0, result}, {16'b0, vecs[i].res});
    chk($sformatf("v%0d tag", i), {28'b0, tag_out}, {28'b0, vecs[i].t});
    chk($sformatf("v%0d ovf", i), {31'b0, ovf}, {31'b0, vecs[i].ovf});
    chk($sformatf("v%0d unf", i), {31'b0, unf}, {31'b0, vecs[i].unf});
    chk($sformatf("v%0d trunc_valid", i), {31'b0, out_valid_t}, 32'd1);
    chk($sformatf("v%0d trunc_result", i), {16'b0, result_t}, {16'b0, vecs[i].res_trunc});
  endtask

  initial begin
    logic [W-1:0]  bp_b[6];
    logic [W-1:0]  held_res;
    logic [TW-1:0] held_tag;
    logic          have_held;
    int            sent, got, extra;

    vecs[0]  = '{16'h3FC0, 16'h4000, 4'h5, 16'h4040, 16'h4040, 1'b0, 1'b0};
    vecs[1]  = '{16'h3FC1, 16'h3FC1, 4'h1, 16'h4012, 16'h4011, 1'b0, 1'b0};
    vecs[2]  = '{16'hBF80, 16'h3F80, 4'h2, 16'hBF80, 16'hBF80, 1'b0, 1'b0};
    vecs[3]  = '{16'h8000, 16'h3F80, 4'h3, 16'h8000, 16'h8000, 1'b0, 1'b0};
    vecs[4]  = '{16'h0000, 16'h7F00, 4'h4, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[5]  = '{16'h7FFF, 16'h4000, 4'h6, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0};
    vecs[6]  = '{16'h0080, 16'h0080, 4'h7, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[7]  = '{16'h3FB5, 16'h3FB5, 4'h8, 16'h4000, 16'h3FFF, 1'b0, 1'b0};
    vecs[8]  = '{16'h3FC0, 16'h3FAE, 4'h9, 16'h4002, 16'h4002, 1'b0, 1'b0};
    vecs[9]  = '{16'h3FC0, 16'h3FB2, 4'hA, 16'h4006, 16'h4005, 1'b0, 1'b0};
    vecs[10] = '{16'h7F00, 16'h3F80, 4'hB, 16'h7F00, 16'h7F00, 1'b0, 1'b0};
    vecs[11] = '{16'h7F00, 16'h4000, 4'hC, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0};
    vecs[12] = '{16'h0080, 16'h3F80, 4'hD, 16'h0080, 16'h0080, 1'b0, 1'b0};
    vecs[13] = '{16'h0080, 16'h3F00, 4'hE, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[14] = '{16'hFFFF, 16'h4000, 4'hF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
    vecs[15] = '{16'h7FFF, 16'h0000, 4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[16] = '{16'h8080, 16'h0080, 4'h3, 16'h8000, 16'h8000, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; tag = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst result", {16'b0, result}, 32'd0);
    chk("rst tag", {28'b0, tag_out}, 32'd0);
    chk("rst flags", {30'b0, ovf, unf}, 32'd0);
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < NV; i++) run_one(i);

    // Backpressure: 1.0 * b_i == b_i, so every result is known in advance.
    for (int i = 0; i < 6; i++) bp_b[i] = 16'h4000 + W'(i * 16'h10);
    tick();
    out_ready = 1'b0; sent = 0; have_held = 1'b0;
    held_res = '0; held_tag = '0;
    for (int c = 0; c < 5; c++) begin
      op_a = 16'h3F80; op_b = bp_b[sent]; tag = TW'(sent); in_valid = 1'b1;
      #1;
      if (out_valid) begin
        if (have_held) begin
          chk($sformatf("stall stable result c%0d", c), {16'b0, result}, {16'b0, held_res});
          chk($sformatf("stall stable tag c%0d", c), {28'b0, tag_out}, {28'b0, held_tag});
        end else begin
          held_res = result; held_tag = tag_out; have_held = 1'b1;
          chk("stall head result", {16'b0, result}, {16'b0, bp_b[0]});
        end
      end
      if (in_ready) sent++;
      tick();
    end
    chk("stall accepted", sent, 32'd3);
    chk("stall in_ready low", {31'b0, in_ready}, 32'd0);

    out_ready = 1'b1; got = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      in_valid = (sent < 6);
      if (sent < 6) begin
        op_a = 16'h3F80; op_b = bp_b[sent]; tag = TW'(sent);
      end
      #1;
      if (out_valid) begin
        chk($sformatf("bp result %0d", got), {16'b0, result}, {16'b0, bp_b[got]});
        chk($sformatf("bp tag %0d", got), {28'b0, tag_out}, got);
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    chk("bp results drained", got, 32'd6);
    in_valid = 1'b0;
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid) extra++;
      tick();
    end
    chk("bp no duplicates", extra, 32'd0);

    // Reset with two operations in flight.
    out_ready = 1'b1;
    op_a = 16'h3FC0; op_b = 16'h4000; tag = 4'h9; in_valid = 1'b1;
    tick();
    op_a = 16'h3F80; op_b = 16'h3F80; tag = 4'hA;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst out_valid", {31'b0, out_valid}, 32'd0);
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid) extra++;
      tick();
    end
    chk("midrst no stale", extra, 32'd0);
    run_one(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
